// File: rtl/player_sprite_fetch_if.sv
// player_sprite_fetch_if
//   Read port between the sprite fetch pipeline and the player sprite ROM.
//   rom_addr : 16-bit read address, registered by the fetch block
//   rom_data : 2-bit palette index, valid one Clk after rom_addr
//   Modports:
//     master - the fetch block (drives rom_addr, reads rom_data)
//     slave  - the ROM (reads rom_addr, drives rom_data)
interface player_sprite_fetch_if;
  logic [15:0] rom_addr;
  logic [1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/player_sprite_fetch.sv
// player_sprite_fetch
//   Pixel pipeline that turns the current scan position into a player sprite
//   ROM read and returns a registered palette index, plus a small animation
//   sequencer that steps the sprite frame on vertical-sync edges.
//   Ports:
//     Clk, Reset_n      - system clock, asynchronous active-low reset
//     frame_clk         - vertical-sync level, sampled in the Clk domain
//     DrawX, DrawY      - current scan pixel
//     PosX, PosY        - sprite top-left corner
//     anim_en           - run the animation sequencer
//     flip              - mirror the sprite horizontally
//     rom               - ROM read port (rom_addr out, rom_data in)
//     pixel_index       - registered palette index (0 = transparent)
//     pixel_valid       - visible, non-transparent sprite pixel
//     frame_sel         - current animation frame
//   Latency from scan inputs to pixel_index/pixel_valid is 3 Clk:
//   address register, ROM read, output register.
module player_sprite_fetch #(
  parameter int SPRITE_W   = 60,
  parameter int SPRITE_H   = 100,
  parameter int NUM_FRAMES = 6,
  parameter int FRAME_HOLD = 4
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_clk,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [9:0]                  PosX,
  input  logic [9:0]                  PosY,
  input  logic                        anim_en,
  input  logic                        flip,
  player_sprite_fetch_if.master       rom,
  output logic [1:0]                  pixel_index,
  output logic                        pixel_valid,
  output logic [2:0]                  frame_sel
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [2:0]        FRAME_LAST = 3'(NUM_FRAMES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_next;
  logic [2:0]         frame_next;
  logic               frame_clk_q;
  logic               tick;

  logic [10:0]        draw_x_ext;
  logic [10:0]        draw_y_ext;
  logic [10:0]        pos_x_ext;
  logic [10:0]        pos_y_ext;
  logic               in_box;
  logic [9:0]         rel_x;
  logic [9:0]         rel_y;
  logic [9:0]         col;
  logic [15:0]        addr_next;

  logic [15:0]        rom_addr_q;
  logic               in_box_d1;
  logic               in_box_d2;

  // Rising-edge detect on the sync level; frame_clk_q resets low so a level
  // already high at reset release counts as an edge.
  assign tick = frame_clk & ~frame_clk_q;

  // Animation state, hold counter and frame register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      frame_sel   <= 3'd0;
      frame_clk_q <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      frame_sel   <= frame_next;
      frame_clk_q <= frame_clk;
    end
  end

  // Sequencer next-state: leaving RUN clears the frame in the same cycle and
  // drops any coincident tick.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    frame_next = frame_sel;
    case (state)
      IDLE: begin
        hold_next  = '0;
        frame_next = 3'd0;
        if (anim_en) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (!anim_en) begin
          state_next = IDLE;
          hold_next  = '0;
          frame_next = 3'd0;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_next = '0;
            if (frame_sel == FRAME_LAST) begin
              frame_next = 3'd0;
            end else begin
              frame_next = frame_sel + 3'd1;
            end
          end else begin
            hold_next = hold_cnt + HOLD_ONE;
          end
        end else begin
          hold_next = hold_cnt;
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = '0;
        frame_next = 3'd0;
      end
    endcase
  end

  // Bounding box in 11 bits so a sprite near the right/bottom edge does not
  // wrap around and match small scan coordinates.
  always_comb begin
    draw_x_ext = {1'b0, DrawX};
    draw_y_ext = {1'b0, DrawY};
    pos_x_ext  = {1'b0, PosX};
    pos_y_ext  = {1'b0, PosY};
    in_box     = (draw_x_ext >= pos_x_ext) && (draw_x_ext < pos_x_ext + 11'(SPRITE_W)) &&
                 (draw_y_ext >= pos_y_ext) && (draw_y_ext < pos_y_ext + 11'(SPRITE_H));
  end

  // ROM address for the current pixel; arithmetic is done modulo 2^16.
  always_comb begin
    rel_x = DrawX - PosX;
    rel_y = DrawY - PosY;
    if (flip) begin
      col = 10'(SPRITE_W - 1) - rel_x;
    end else begin
      col = rel_x;
    end
    if (in_box) begin
      addr_next = 16'(frame_sel) * 16'(SPRITE_W * SPRITE_H) +
                  16'(rel_y) * 16'(SPRITE_W) + 16'(col);
    end else begin
      addr_next = 16'd0;
    end
  end

  // Pixel pipeline: address register, ROM read alignment, output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q  <= 16'd0;
      in_box_d1   <= 1'b0;
      in_box_d2   <= 1'b0;
      pixel_index <= 2'd0;
      pixel_valid <= 1'b0;
    end else begin
      rom_addr_q  <= addr_next;
      in_box_d1   <= in_box;
      in_box_d2   <= in_box_d1;
      pixel_index <= in_box_d2 ? rom.rom_data : 2'd0;
      pixel_valid <= in_box_d2 & (rom.rom_data != 2'd0);
    end
  end

  assign rom.rom_addr = rom_addr_q;

endmodule
